// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the byte-serialized CPU bus: frame geometry, rw
// encoding and the frame FSM states. Used by both ends of the link.
package cpu_bus_pkg;

  localparam int FRAME_LEN = 10;

  localparam logic [3:0] SLOT_ADDR0 = 4'd1;
  localparam logic [3:0] SLOT_RW    = 4'd5;
  localparam logic [3:0] SLOT_RD0   = 4'd6;
  localparam logic [3:0] SLOT_LAST  = 4'(FRAME_LEN - 1);

  localparam logic RW_READ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RW,
    ST_XFER
  } state_e;

  // Little-endian byte select: idx 0 is bits [7:0].
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// Host byte lanes plus the word-wide memory port of the bus responder.
// The responder is the slave; the host/memory side (or a bench) is the master.
interface cpu_bus_responder_if;

  logic        frame_sync;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_oe;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output frame_sync, bus_addr, bus_wdata, mem_ack, mem_rdata,
    input  bus_rdata, bus_rdata_oe, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  frame_sync, bus_addr, bus_wdata, mem_ack, mem_rdata,
    output bus_rdata, bus_rdata_oe, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cpu_bus_byte_shifter.sv
// Four-byte capture register: writes byte_i into byte lane idx_i when we_i.
// Used to assemble the address and write-data words from the serial lanes.
module cpu_bus_byte_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [1:0]  idx_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  logic [31:0] word_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this word also drives an output, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (we_i) begin
      word_q[{idx_i, 3'b000} +: 8] <= byte_i;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side end of the byte-serialized CPU bus: deserializes one 10-slot
// frame into a word access on a req/ack port and serializes read data back.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_bus_responder_if.slave  bus,
  input  logic                err_clr,
  output logic                late_err,
  output logic                sync_err,
  output logic                frame_done
);

  state_e      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic        rw_q, rw_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        ack_seen_q, ack_seen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        late_err_q, late_err_d;
  logic        sync_err_q, sync_err_d;

  logic        cap_we;
  logic [1:0]  cap_idx;
  logic [1:0]  rd_idx;
  logic        ack_valid;
  logic        late_set;
  logic        sync_set;
  logic        rdata_oe;
  logic [7:0]  rdata_byte;
  logic        done;

  // An ack only counts while a request is outstanding.
  assign ack_valid = bus.mem_ack & mem_req_q;
  assign cap_idx   = slot_q[1:0] - 2'd1;
  // Slots 6..9 map to read bytes 0..3 (6 = 4'b0110, so low bits + 2 wrap to 0).
  assign rd_idx    = slot_q[1:0] + 2'd2;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    rw_d       = rw_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    ack_seen_d = ack_seen_q;
    rdata_d    = rdata_q;
    cap_we     = 1'b0;
    late_set   = 1'b0;
    sync_set   = 1'b0;
    rdata_oe   = 1'b0;
    rdata_byte = IDLE_BYTE;
    done       = 1'b0;

    if (ack_valid) begin
      mem_req_d = 1'b0;
    end

    if (bus.frame_sync) begin
      // The sync cycle is slot 0 of a new frame; mid-frame it aborts the old one.
      sync_set   = (state_q != ST_IDLE);
      state_d    = ST_ADDR;
      slot_d     = SLOT_ADDR0;
      mem_req_d  = 1'b0;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          slot_d = '0;
        end
        ST_ADDR: begin
          cap_we = 1'b1;
          slot_d = slot_q + 4'd1;
          if (slot_q == SLOT_RW - 4'd1) begin
            state_d = ST_RW;
          end
        end
        ST_RW: begin
          rw_d      = bus.bus_addr[0];
          mem_req_d = 1'b1;
          mem_we_d  = ~bus.bus_addr[0];
          slot_d    = SLOT_RD0;
          state_d   = ST_XFER;
        end
        ST_XFER: begin
          if (rw_q == RW_READ) begin
            rdata_oe = 1'b1;
            if (ack_seen_q) begin
              rdata_byte = get_byte(rdata_q, rd_idx);
            end else if (ack_valid) begin
              rdata_byte = get_byte(bus.mem_rdata, rd_idx);
              rdata_d    = bus.mem_rdata;
              ack_seen_d = 1'b1;
            end else begin
              late_set = 1'b1;
            end
          end
          if (slot_q == SLOT_LAST) begin
            done       = 1'b1;
            state_d    = ST_IDLE;
            slot_d     = '0;
            ack_seen_d = 1'b0;
            mem_req_d  = 1'b0;
            if (mem_req_q && !ack_valid) begin
              late_set = 1'b1;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end
      endcase
    end

    // A set in the same cycle as err_clr wins.
    late_err_d = late_set | (late_err_q & ~err_clr);
    sync_err_d = sync_set | (sync_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      rw_q       <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      ack_seen_q <= 1'b0;
      rdata_q    <= '0;
      late_err_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      rw_q       <= rw_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      ack_seen_q <= ack_seen_d;
      rdata_q    <= rdata_d;
      late_err_q <= late_err_d;
      sync_err_q <= sync_err_d;
    end
  end

  cpu_bus_byte_shifter u_addr_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (cap_we),
    .idx_i  (cap_idx),
    .byte_i (bus.bus_addr),
    .word_o (bus.mem_addr)
  );

  cpu_bus_byte_shifter u_wdata_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (cap_we),
    .idx_i  (cap_idx),
    .byte_i (bus.bus_wdata),
    .word_o (bus.mem_wdata)
  );

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.bus_rdata    = rdata_byte;
  assign bus.bus_rdata_oe = rdata_oe;
  assign late_err         = late_err_q;
  assign sync_err         = sync_err_q;
  assign frame_done       = done;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: one slot per clock, inputs driven on
// the falling edge and outputs compared 1 ns later.
module tb_cpu_bus_responder;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic late_err, sync_err, frame_done;

  int n_checks = 0;
  int n_fail = 0;

  cpu_bus_responder_if bus_if ();

  cpu_bus_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .err_clr    (err_clr),
    .late_err   (late_err),
    .sync_err   (sync_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        clr;
    logic        e_req;
    logic        e_oe;
    logic [7:0]  e_rd;
    logic        e_late;
    logic        e_sync;
    logic        e_done;
    logic        chk_mem;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fs, input logic [7:0] a, input logic [7:0] w,
                              input logic ack, input logic [31:0] rd_in, input logic clr,
                              input logic e_req, input logic e_oe, input logic [7:0] e_rd,
                              input logic e_late, input logic e_sync, input logic e_done);
    vec_t v;
    v.fs = fs;  v.addr = a;  v.wdata = w;  v.ack = ack;  v.rdata = rd_in;  v.clr = clr;
    v.e_req = e_req;  v.e_oe = e_oe;  v.e_rd = e_rd;
    v.e_late = e_late;  v.e_sync = e_sync;  v.e_done = e_done;
    v.chk_mem = 1'b0;  v.e_we = 1'b0;  v.e_addr = '0;  v.e_wdata = '0;
    return v;
  endfunction

  function automatic vec_t with_mem(input vec_t v, input logic [31:0] a,
                                    input logic [31:0] w, input logic we);
    vec_t r = v;
    r.chk_mem = 1'b1;  r.e_addr = a;  r.e_wdata = w;  r.e_we = we;
    return r;
  endfunction

  // Slots 0..5 of a frame: sync, four address/data bytes, rw byte.
  task automatic add_setup(input logic [31:0] a, input logic [31:0] w, input logic rw,
                           input logic late, input logic sync);
    logic [31:0] aw, ww;
    aw = a;
    ww = w;
    vecs.push_back(mk(1'b1, 8'h00, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'h00, late, sync, 1'b0));
    for (int s = 0; s < 4; s++) begin
      vecs.push_back(mk(1'b0, aw[8*s +: 8], ww[8*s +: 8], 1'b0, '0, 1'b0,
                        1'b0, 1'b0, 8'h00, late, sync, 1'b0));
    end
    vecs.push_back(mk(1'b0, {7'd0, rw}, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'h00, late, sync, 1'b0));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus_if.frame_sync = v.fs;
    bus_if.bus_addr   = v.addr;
    bus_if.bus_wdata  = v.wdata;
    bus_if.mem_ack    = v.ack;
    bus_if.mem_rdata  = v.rdata;
    err_clr           = v.clr;
    #1;
    check({tag, ".mem_req"},  {31'd0, bus_if.mem_req},      {31'd0, v.e_req});
    check({tag, ".oe"},       {31'd0, bus_if.bus_rdata_oe}, {31'd0, v.e_oe});
    check({tag, ".rdata"},    {24'd0, bus_if.bus_rdata},    {24'd0, v.e_rd});
    check({tag, ".late_err"}, {31'd0, late_err},            {31'd0, v.e_late});
    check({tag, ".sync_err"}, {31'd0, sync_err},            {31'd0, v.e_sync});
    check({tag, ".done"},     {31'd0, frame_done},          {31'd0, v.e_done});
    if (v.chk_mem) begin
      check({tag, ".mem_we"},    {31'd0, bus_if.mem_we}, {31'd0, v.e_we});
      check({tag, ".mem_addr"},  bus_if.mem_addr,        v.e_addr);
      check({tag, ".mem_wdata"}, bus_if.mem_wdata,       v.e_wdata);
    end
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[i]) apply(vecs[i], $sformatf("%s[%0d]", name, i));
    vecs.delete();
  endtask

  initial begin
    bus_if.frame_sync = 1'b0;
    bus_if.bus_addr   = 8'h00;
    bus_if.bus_wdata  = 8'h00;
    bus_if.mem_ack    = 1'b0;
    bus_if.mem_rdata  = '0;

    #1;
    check("reset.mem_req",   {31'd0, bus_if.mem_req},      32'd0);
    check("reset.mem_we",    {31'd0, bus_if.mem_we},       32'd0);
    check("reset.mem_addr",  bus_if.mem_addr,              32'd0);
    check("reset.mem_wdata", bus_if.mem_wdata,             32'd0);
    check("reset.oe",        {31'd0, bus_if.bus_rdata_oe}, 32'd0);
    check("reset.rdata",     {24'd0, bus_if.bus_rdata},    32'd0);
    check("reset.errs",      {30'd0, late_err, sync_err},  32'd0);
    check("reset.done",      {31'd0, frame_done},          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: write with ack in slot 7, zero-latency read, read acked in slot 8.
    add_setup(32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    vecs.push_back(with_mem(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 0, 8'h00, 0, 0, 0),
                            32'h1234_5678, 32'hDEAD_BEEF, 1'b1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, '0, 0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 1));
    add_setup(32'h4030_2010, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs.push_back(with_mem(mk(0, 8'h00, 8'h00, 1, 32'hCAFE_F00D, 0, 1, 1, 8'h0D, 0, 0, 0),
                            32'h4030_2010, 32'h0, 1'b0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 1, 8'hF0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 1, 8'hFE, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 1, 8'hCA, 0, 0, 1));
    add_setup(32'hA0B0_C0D0, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 1, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 32'h1122_3344, 0, 1, 1, 8'h22, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 1, 8'h11, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 1, 0, 0, 8'h00, 1, 0, 0));
    // Stray ack while idle must be ignored.
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 32'hFFFF_FFFF, 0, 0, 0, 8'h00, 0, 0, 0));
    run_vecs("table");

    // No ack by slot 9: request aborted, late_err set, then cleared.
    add_setup(32'h0000_0100, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
    for (int s = 6; s <= 9; s++) begin
      vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 0, 8'h00, 0, 0, logic'(s == 9)));
    end
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 1, 0, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    run_vecs("noack");

    // Ack coinciding with the slot-9 abort counts as served.
    add_setup(32'h0000_0200, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    for (int s = 6; s <= 9; s++) begin
      vecs.push_back(mk(0, 8'h00, 8'h00, logic'(s == 9), '0, 0, 1, 0, 8'h00, 0, 0,
                        logic'(s == 9)));
    end
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    run_vecs("ack9");

    // frame_sync in slot 3 restarts the frame; new bytes overwrite old ones.
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h11, 8'h99, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h22, 8'h88, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    add_setup(32'h0BAD_F00D, 32'h0123_4567, 1'b0, 1'b0, 1'b1);
    vecs[3].e_sync = 1'b0;  // flag rises at the end of the restarting sync slot
    vecs.push_back(with_mem(mk(0, 8'h00, 8'h00, 1, '0, 0, 1, 0, 8'h00, 0, 1, 0),
                            32'h0BAD_F00D, 32'h0123_4567, 1'b1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 1, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    run_vecs("resync");

    // Asynchronous reset in slot 7 of a pending read.
    add_setup(32'hBEEF_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 1, 8'h00, 1, 0, 0));
    run_vecs("prerst");
    rst_n = 1'b0;
    #1;
    check("rst.mem_req",  {31'd0, bus_if.mem_req},      32'd0);
    check("rst.oe",       {31'd0, bus_if.bus_rdata_oe}, 32'd0);
    check("rst.rdata",    {24'd0, bus_if.bus_rdata},    32'd0);
    check("rst.late_err", {31'd0, late_err},            32'd0);
    check("rst.mem_addr", bus_if.mem_addr,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(0, 8'h01, 8'h00, 0, '0, 0, 0, 0, 8'h00, 0, 0, 0));
    end
    add_setup(32'h7654_3210, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 1, 1, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 32'h8899_AABB, 0, 1, 1, 8'hAA, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 1, 8'h99, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, '0, 0, 0, 1, 8'h88, 1, 0, 1));
    run_vecs("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
